keypad_lock_ctrl: RTL and testbench

KEYPAD_LOCK_CTRL -- requirements
Module: keypad_lock_ctrl

---
 rtl/keypad_lock_pkg.sv | 21 ++
 rtl/keypad_lock_ctrl_timer.sv | 27 ++
 rtl/keypad_lock_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_keypad_lock_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_lock_pkg.sv
// Shared types and key codes for the keypad lock controller.
// Imported by the lock FSM and its timer.
package keypad_lock_pkg;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_ENTRY,
    S_UNLOCKED,
    S_PROG,
    S_LOCKOUT
  } state_t;

  localparam logic [3:0] KEY_PROG  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_timer.sv
// Loadable down-counter shared by the timeout, unlock and lockout phases.
// Saturates at zero; o_zero marks the expiry cycle.
module lock_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad door lock: PIN entry, retry lockout and in-place PIN change.
// All outputs are registered from the next-state decode.
module keypad_lock_ctrl
  import keypad_lock_pkg::*;
#(
  parameter int PW_LEN = 4,
  parameter logic [PW_LEN*4-1:0] DEFAULT_PW = 16'h1234,
  parameter int MAX_FAIL    = 3,
  parameter int TIMEOUT_CYC = 500000,
  parameter int UNLOCK_CYC  = 2000000,
  parameter int LOCKOUT_CYC = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_val,
  input  logic       key_valid,
  output logic       unlocked,
  output logic       locked,
  output logic       lockout,
  output logic       entry_active,
  output logic       prog_mode,
  output logic [3:0] attempts_left,
  output logic       fail_pulse,
  output logic       pw_changed
);

  localparam int PW_W = PW_LEN * 4;
  localparam int MX1  = (TIMEOUT_CYC > UNLOCK_CYC) ? TIMEOUT_CYC : UNLOCK_CYC;
  localparam int MAXC = (MX1 > LOCKOUT_CYC) ? MX1 : LOCKOUT_CYC;
  localparam int TW   = (MAXC > 2) ? $clog2(MAXC) : 1;

  state_t          r_state, w_nxt;
  logic [PW_W-1:0] r_pw, r_buf, w_pw, w_buf;
  logic [3:0]      r_cnt, w_cnt, r_fail, w_fail;
  logic            r_ovf, w_ovf;
  logic            w_fp, w_pc, w_rld, w_load, w_zero;
  logic [TW-1:0]   w_lval;
  logic            w_dig, w_ent, w_clr, w_prg, w_room, w_full;

  // Loading CYC-1 makes a phase last exactly CYC cycles.
  function automatic logic [TW-1:0] load_of(input state_t s);
    case (s)
      S_ENTRY, S_PROG: return TW'(TIMEOUT_CYC - 1);
      S_UNLOCKED:      return TW'(UNLOCK_CYC - 1);
      S_LOCKOUT:       return TW'(LOCKOUT_CYC - 1);
      default:         return '0;
    endcase
  endfunction

  assign w_dig  = key_valid && is_digit(key_val);
  assign w_ent  = key_valid && (key_val == KEY_ENTER);
  assign w_clr  = key_valid && (key_val == KEY_CLEAR);
  assign w_prg  = key_valid && (key_val == KEY_PROG);
  assign w_room = r_cnt < 4'(PW_LEN);
  assign w_full = (r_cnt == 4'(PW_LEN)) && !r_ovf;

  always_comb begin
    w_nxt  = r_state;
    w_pw   = r_pw;
    w_buf  = r_buf;
    w_cnt  = r_cnt;
    w_ovf  = r_ovf;
    w_fail = r_fail;
    w_fp   = 1'b0;
    w_pc   = 1'b0;
    w_rld  = 1'b0;
    case (r_state)
      S_LOCKED: begin
        if (w_dig) begin
          w_nxt = S_ENTRY;
          w_buf = PW_W'(key_val);
          w_cnt = 4'd1;
          w_ovf = 1'b0;
        end
      end
      S_ENTRY: begin
        if (w_zero) begin
          w_nxt = S_LOCKED;
        end else if (w_dig) begin
          w_rld = 1'b1;
          if (w_room) begin
            w_buf = PW_W'({r_buf, key_val});
            w_cnt = r_cnt + 4'd1;
          end else begin
            w_ovf = 1'b1;
          end
        end else if (w_ent) begin
          if (w_full && (r_buf == r_pw)) begin
            w_nxt  = S_UNLOCKED;
            w_fail = '0;
          end else begin
            w_fp   = 1'b1;
            w_fail = r_fail + 4'd1;
            w_nxt  = (w_fail == 4'(MAX_FAIL)) ? S_LOCKOUT : S_LOCKED;
          end
        end else if (w_clr) begin
          w_nxt = S_LOCKED;
        end
      end
      S_UNLOCKED: begin
        if (w_zero || w_ent) begin
          w_nxt = S_LOCKED;
        end else if (w_prg) begin
          w_nxt = S_PROG;
          w_cnt = '0;
          w_ovf = 1'b0;
        end
      end
      S_PROG: begin
        if (w_zero || w_clr) begin
          w_nxt = S_UNLOCKED;
        end else if (w_dig) begin
          w_rld = 1'b1;
          if (w_room) begin
            w_buf = PW_W'({r_buf, key_val});
            w_cnt = r_cnt + 4'd1;
          end else begin
            w_ovf = 1'b1;
          end
        end else if (w_ent) begin
          w_nxt = S_UNLOCKED;
          if (w_full) begin
            w_pw = r_buf;
            w_pc = 1'b1;
          end else begin
            w_fp = 1'b1;
          end
        end
      end
      S_LOCKOUT: begin
        if (w_zero) begin
          w_nxt  = S_LOCKED;
          w_fail = '0;
        end
      end
      default: w_nxt = S_LOCKED;
    endcase
    w_load = w_rld || (w_nxt != r_state);
    w_lval = load_of(w_nxt);
  end

  lock_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_val  (w_lval),
    .o_zero (w_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_LOCKED;
      r_pw          <= DEFAULT_PW;
      r_buf         <= '0;
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_fail        <= '0;
      unlocked      <= 1'b0;
      locked        <= 1'b1;
      lockout       <= 1'b0;
      entry_active  <= 1'b0;
      prog_mode     <= 1'b0;
      attempts_left <= 4'(MAX_FAIL);
      fail_pulse    <= 1'b0;
      pw_changed    <= 1'b0;
    end else begin
      r_state       <= w_nxt;
      r_pw          <= w_pw;
      r_buf         <= w_buf;
      r_cnt         <= w_cnt;
      r_ovf         <= w_ovf;
      r_fail        <= w_fail;
      unlocked      <= (w_nxt == S_UNLOCKED) || (w_nxt == S_PROG);
      locked        <= !((w_nxt == S_UNLOCKED) || (w_nxt == S_PROG));
      lockout       <= (w_nxt == S_LOCKOUT);
      entry_active  <= (w_nxt == S_ENTRY);
      prog_mode     <= (w_nxt == S_PROG);
      attempts_left <= 4'(MAX_FAIL) - w_fail;
      fail_pulse    <= w_fp;
      pw_changed    <= w_pc;
    end
  end

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with shortened timers.
// Keys are driven on falling edges; outputs are checked on falling edges.
module tb_keypad_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_val;
  logic       key_valid;
  logic       unlocked, locked, lockout, entry_active, prog_mode;
  logic [3:0] attempts_left;
  logic       fail_pulse, pw_changed;

  int n_chk  = 0;
  int n_fail = 0;

  keypad_lock_ctrl #(
    .PW_LEN(4), .DEFAULT_PW(16'h1234), .MAX_FAIL(3),
    .TIMEOUT_CYC(16), .UNLOCK_CYC(32), .LOCKOUT_CYC(64)
  ) dut (
    .clk(clk), .rst(rst), .key_val(key_val), .key_valid(key_valid),
    .unlocked(unlocked), .locked(locked), .lockout(lockout),
    .entry_active(entry_active), .prog_mode(prog_mode),
    .attempts_left(attempts_left), .fail_pulse(fail_pulse),
    .pw_changed(pw_changed)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the next falling edge.
  task automatic send(input logic [3:0] k);
    key_val   = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic pin(input logic [15:0] d);
    for (int i = 3; i >= 0; i--) send(d[i*4 +: 4]);
  endtask

  task automatic test_reset;
    n_chk++;
    if ({unlocked, locked, lockout, entry_active, prog_mode,
         attempts_left, fail_pulse, pw_changed} !== 11'b01000_0011_00) begin
      n_fail++;
      $display("FAIL reset_outputs: got u=%b l=%b lo=%b e=%b p=%b a=%0d f=%b c=%b",
               unlocked, locked, lockout, entry_active, prog_mode,
               attempts_left, fail_pulse, pw_changed);
    end
  endtask

  task automatic test_ignored;
    send(4'hB); send(4'hD); send(4'hE);
    send(4'hA); send(4'hF); send(4'hC);
    n_chk++;
    if (locked !== 1'b1 || entry_active !== 1'b0 || fail_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_in_locked: l=%b e=%b f=%b want 1 0 0",
               locked, entry_active, fail_pulse);
    end
  endtask

  task automatic test_unlock;
    send(4'h1);
    n_chk++;
    if (entry_active !== 1'b1) begin
      n_fail++;
      $display("FAIL entry_after_digit: entry_active=%b want 1", entry_active);
    end
    send(4'h2); send(4'h3); send(4'h4); send(4'hF);
    n_chk++;
    if (unlocked !== 1'b1 || locked !== 1'b0 || entry_active !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_1234: u=%b l=%b e=%b want 1 0 0",
               unlocked, locked, entry_active);
    end
    repeat (31) @(negedge clk);
    n_chk++;
    if (unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock_hold_32: unlocked=%b want 1", unlocked);
    end
    @(negedge clk);
    n_chk++;
    if (locked !== 1'b1 || unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL unlock_expire: l=%b u=%b want 1 0", locked, unlocked);
    end
  endtask

  task automatic test_fail_lockout;
    pin(16'h1235); send(4'hF);
    n_chk++;
    if (fail_pulse !== 1'b1 || attempts_left !== 4'd2 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL fail1: f=%b a=%0d l=%b want 1 2 1",
               fail_pulse, attempts_left, locked);
    end
    @(negedge clk);
    n_chk++;
    if (fail_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL fail_pulse_width: fail_pulse=%b want 0", fail_pulse);
    end
    send(4'h9); send(4'hF);
    n_chk++;
    if (fail_pulse !== 1'b1 || attempts_left !== 4'd1) begin
      n_fail++;
      $display("FAIL fail2_short: f=%b a=%0d want 1 1", fail_pulse, attempts_left);
    end
    pin(16'h1234); send(4'h5); send(4'hF);
    n_chk++;
    if (fail_pulse !== 1'b1 || attempts_left !== 4'd0 || lockout !== 1'b1) begin
      n_fail++;
      $display("FAIL fail3_overflow_lockout: f=%b a=%0d lo=%b want 1 0 1",
               fail_pulse, attempts_left, lockout);
    end
    pin(16'h1234); send(4'hF);
    n_chk++;
    if (lockout !== 1'b1 || unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL lockout_ignores_keys: lo=%b u=%b want 1 0", lockout, unlocked);
    end
    repeat (58) @(negedge clk);
    n_chk++;
    if (lockout !== 1'b1) begin
      n_fail++;
      $display("FAIL lockout_hold_64: lockout=%b want 1", lockout);
    end
    @(negedge clk);
    n_chk++;
    if (lockout !== 1'b0 || locked !== 1'b1 || attempts_left !== 4'd3) begin
      n_fail++;
      $display("FAIL lockout_expire: lo=%b l=%b a=%0d want 0 1 3",
               lockout, locked, attempts_left);
    end
    pin(16'h1234); send(4'hF);
    n_chk++;
    if (unlocked !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock_after_lockout: unlocked=%b want 1", unlocked);
    end
    send(4'hF);
    n_chk++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock_enter: locked=%b want 1", locked);
    end
  endtask

  task automatic test_clear;
    send(4'h1); send(4'h2); send(4'hC);
    n_chk++;
    if (locked !== 1'b1 || entry_active !== 1'b0 || fail_pulse !== 1'b0 ||
        attempts_left !== 4'd3) begin
      n_fail++;
      $display("FAIL clear_entry: l=%b e=%b f=%b a=%0d want 1 0 0 3",
               locked, entry_active, fail_pulse, attempts_left);
    end
  endtask

  task automatic test_prog;
    pin(16'h1234); send(4'hF); send(4'hA);
    n_chk++;
    if (prog_mode !== 1'b1 || unlocked !== 1'b1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_enter: p=%b u=%b l=%b want 1 1 0",
               prog_mode, unlocked, locked);
    end
    send(4'h1); send(4'h2); send(4'hF);
    n_chk++;
    if (fail_pulse !== 1'b1 || prog_mode !== 1'b0 || unlocked !== 1'b1 ||
        pw_changed !== 1'b0 || attempts_left !== 4'd3) begin
      n_fail++;
      $display("FAIL prog_short: f=%b p=%b u=%b c=%b a=%0d want 1 0 1 0 3",
               fail_pulse, prog_mode, unlocked, pw_changed, attempts_left);
    end
    send(4'hA); pin(16'h5678); send(4'hF);
    n_chk++;
    if (pw_changed !== 1'b1 || unlocked !== 1'b1 || prog_mode !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_commit: c=%b u=%b p=%b want 1 1 0",
               pw_changed, unlocked, prog_mode);
    end
    @(negedge clk);
    n_chk++;
    if (pw_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL pw_changed_width: pw_changed=%b want 0", pw_changed);
    end
    send(4'hF);
    pin(16'h1234); send(4'hF);
    n_chk++;
    if (fail_pulse !== 1'b1 || locked !== 1'b1 || attempts_left !== 4'd2) begin
      n_fail++;
      $display("FAIL old_pw_rejected: f=%b l=%b a=%0d want 1 1 2",
               fail_pulse, locked, attempts_left);
    end
    pin(16'h5678); send(4'hF);
    n_chk++;
    if (unlocked !== 1'b1 || attempts_left !== 4'd3) begin
      n_fail++;
      $display("FAIL new_pw_accepted: u=%b a=%0d want 1 3", unlocked, attempts_left);
    end
    send(4'hF);
  endtask

  task automatic test_timeout;
    send(4'h1); send(4'h2);
    repeat (15) @(negedge clk);
    n_chk++;
    if (entry_active !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hold: entry_active=%b want 1", entry_active);
    end
    send(4'h5);
    n_chk++;
    if (entry_active !== 1'b0 || locked !== 1'b1 || attempts_left !== 4'd3 ||
        fail_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_expiry_wins: e=%b l=%b a=%0d f=%b want 0 1 3 0",
               entry_active, locked, attempts_left, fail_pulse);
    end
  endtask

  task automatic test_reset_mid_prog;
    pin(16'h5678); send(4'hF);
    send(4'hA); pin(16'h9999); send(4'hF);
    send(4'hA); send(4'h1);
    n_chk++;
    if (prog_mode !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_before_reset: prog_mode=%b want 1", prog_mode);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if (locked !== 1'b1 || unlocked !== 1'b0 || prog_mode !== 1'b0 ||
        attempts_left !== 4'd3) begin
      n_fail++;
      $display("FAIL async_reset: l=%b u=%b p=%b a=%0d want 1 0 0 3",
               locked, unlocked, prog_mode, attempts_left);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pin(16'h9999); send(4'hF);
    n_chk++;
    if (fail_pulse !== 1'b1 || unlocked !== 1'b0) begin
      n_fail++;
      $display("FAIL committed_pw_reverted: f=%b u=%b want 1 0", fail_pulse, unlocked);
    end
    pin(16'h1234); send(4'hF);
    n_chk++;
    if (unlocked !== 1'b1 || attempts_left !== 4'd3) begin
      n_fail++;
      $display("FAIL default_pw_after_reset: u=%b a=%0d want 1 3",
               unlocked, attempts_left);
    end
  endtask

  initial begin
    rst       = 1'b0;
    key_val   = 4'h0;
    key_valid = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_ignored;
    test_unlock;
    test_fail_lockout;
    test_clear;
    test_prog;
    test_timeout;
    test_reset_mid_prog;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
